frame_scaler: RTL and testbench
===============================

FRAME_SCALER -- requirements
Module: frame_scaler

Interface
REQ-001 Parameter SRC_W, default 256, SHALL set the source pixels per line.
REQ-002 Parameter SRC_H, default 240, SHALL set the source lines per frame.
REQ-003 Parameter DST_W, default 640, SHALL set the display active width.
REQ-004 Parameter DST_H, default 480, SHALL set the display active height.
REQ-005 Parameter SCALE, default 2, SHALL set the integer replication factor, horizontal and vertical; SRC_W*SCALE<=DST_W and SRC_H*SCALE<=DST_H.
REQ-006 Parameter PIXEL_BITS, default 24, SHALL set the pixel width, packed as {red,grn,blu}.
REQ-007 Port list, clock and reset first:
 clk  in  1  pixel clock; one clock domain, all logic on the rising edge.
 i_reset_n  in  1  asynchronous active-low reset.
 i_src_valid  in  1  source pixel valid.
 i_src_sof  in  1  qualifies the current source pixel as the first of a frame.
 i_src_pixel  in  PIXEL_BITS  source pixel.
 o_src_ready  out  1  registered; source pixel accepted when valid&&ready.
 o_frame_req  out  1  one-cycle pulse requesting a new source frame.
 i_rd  in  1  display requests one pixel.
 i_newline  in  1  display line-start pulse.
 i_newframe  in  1  display frame-start pulse.
 i_border  in  PIXEL_BITS  colour outside the scaled window.
 o_pixel  out  PIXEL_BITS  display pixel.
 o_underrun  out  1  sticky error flag.
 o_sync_err  out  1  sticky error flag.

Function
REQ-008 Window offsets SHALL be H_OFF=(DST_W-SRC_W*SCALE)/2 and V_OFF=(DST_H-SRC_H*SCALE)/2, truncated; defaults are 64 and 0.
REQ-009 Storage SHALL be two ping-pong line buffers of SRC_W entries, each with a full flag; fill index and read index both reset to 0.
REQ-010 o_src_ready SHALL be 1 iff the buffer at the fill index is not full.
REQ-011 On each accepted pixel, the block SHALL write the buffer at the current write column and increment the column.
REQ-012 On acceptance of pixel SRC_W-1: column->0, fill buffer marked full, fill index toggles, o_src_ready low the next cycle if the other buffer is full.
REQ-013 An accepted pixel with i_src_sof=1 SHALL be written at column 0; if the column was nonzero, the partial line SHALL be discarded and o_sync_err set.
REQ-014 Display counters x (0..DST_W-1) and y (0..DST_H-1) SHALL be maintained: x increments per i_rd, x->0 on i_newline, y increments on i_newline, x,y->0 on i_newframe.
REQ-015 o_pixel SHALL be registered with latency 1: the pixel for the i_rd at cycle n appears at cycle n+1 and holds until the next i_rd.
REQ-016 Inside the window, o_pixel SHALL be buffer[read index][(x-H_OFF)/SCALE]; the division SHALL be a replication counter, not a divider.
REQ-017 Outside the window, o_pixel SHALL be i_border.
REQ-018 If the read buffer is not full at the first in-window i_rd of a line, that line SHALL output i_border and o_underrun SHALL be set.
REQ-019 At i_newline ending the SCALE-th repetition of a source line, the read buffer full flag SHALL clear and the read index SHALL toggle.
REQ-020 A release (REQ-019) and a fill completion (REQ-012) in the same cycle on different buffers SHALL both take effect.
REQ-021 On i_newframe: both full flags cleared, both indices 0, write column 0, o_frame_req pulsed the next cycle.
REQ-022 After REQ-021, source pixels SHALL be dropped (ready held 1, no write) until one arrives with i_src_sof=1.
REQ-023 i_newframe SHALL take priority over a simultaneous i_newline.
REQ-024 An i_rd with x=DST_W-1 SHALL saturate x.

Reset
REQ-025 While i_reset_n=0: o_pixel=0, o_src_ready=0, o_frame_req=0, o_underrun=0, o_sync_err=0; all counters, indices and flags 0.
REQ-026 Reset SHALL act asynchronously mid-line or mid-frame; o_src_ready SHALL be 1 the first cycle after release.
REQ-027 Sticky flags SHALL clear only on reset.

Structure
REQ-028 Package scaler_pkg SHALL hold H_OFF/V_OFF derivation, counter-width (clog2) functions and the default parameters.
REQ-029 Sub-module line_buffer SHALL be a 1-write/1-read synchronous-read RAM of SRC_W x PIXEL_BITS, instantiated twice.

Verification
REQ-030 Defaults; feed 256 pixels of value n; display line 0 -> x 0..63 border; x 64..575 give 0,0,1,1..255,255; x 576..639 border.
REQ-031 Two source lines, then three i_newline -> lines 0,1 show src line 0; line 2 shows src line 1; ready low after the second fill until the first release.
REQ-032 Source idle; display reaches window -> whole line border; o_underrun=1.
REQ-033 i_src_sof at column 100 -> line restarts at 0; o_sync_err=1; the next full line is displayed correctly.
REQ-034 i_newframe mid-frame -> o_frame_req pulse one cycle later; pixels without sof dropped; first sof pixel written at column 0.
REQ-035 Reset asserted mid-line -> all outputs 0 immediately, without waiting for a clock edge; ready=1 the first cycle after release.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared defaults, write-side state encoding and derived-geometry helpers
// for the integer frame scaler.
package scaler_pkg;

  localparam int DEF_SRC_W      = 256;
  localparam int DEF_SRC_H      = 240;
  localparam int DEF_DST_W      = 640;
  localparam int DEF_DST_H      = 480;
  localparam int DEF_SCALE      = 2;
  localparam int DEF_PIXEL_BITS = 24;

  typedef enum logic {
    WR_RUN      = 1'b0,
    WR_WAIT_SOF = 1'b1
  } wr_state_t;

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int h_off(input int dst_w, input int src_w, input int scale);
    return (dst_w - src_w * scale) / 2;
  endfunction

  function automatic int v_off(input int dst_h, input int src_h, input int scale);
    return (dst_h - src_h * scale) / 2;
  endfunction

endpackage

// File: rtl/frame_scaler_if.sv
// Source-pixel stream between a frame producer (master) and the scaler (slave).
interface frame_scaler_if
  import scaler_pkg::*;
#(
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
);

  logic                  valid;
  logic                  sof;
  logic [PIXEL_BITS-1:0] pixel;
  logic                  ready;
  logic                  frame_req;

  modport master (output valid, output sof, output pixel, input ready, input frame_req);
  modport slave  (input valid, input sof, input pixel, output ready, output frame_req);

endinterface

// File: rtl/frame_scaler_line_buffer.sv
// One source line of storage: single write port, registered read port with enable.
module line_buffer
  import scaler_pkg::*;
#(
  parameter int DEPTH = DEF_SRC_W,
  parameter int WIDTH = DEF_PIXEL_BITS,
  localparam int AW   = cw(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_scaler.sv
// Integer-factor scaler: fills two ping-pong line buffers from a source stream
// and replays each source line SCALE times, centred in a bordered display.
module frame_scaler
  import scaler_pkg::*;
#(
  parameter int SRC_W      = DEF_SRC_W,
  parameter int SRC_H      = DEF_SRC_H,
  parameter int DST_W      = DEF_DST_W,
  parameter int DST_H      = DEF_DST_H,
  parameter int SCALE      = DEF_SCALE,
  parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_src_valid,
  input  logic                  i_src_sof,
  input  logic [PIXEL_BITS-1:0] i_src_pixel,
  output logic                  o_src_ready,
  output logic                  o_frame_req,
  input  logic                  i_rd,
  input  logic                  i_newline,
  input  logic                  i_newframe,
  input  logic [PIXEL_BITS-1:0] i_border,
  output logic [PIXEL_BITS-1:0] o_pixel,
  output logic                  o_underrun,
  output logic                  o_sync_err
);

  localparam int AW = cw(SRC_W);
  localparam int XW = cw(DST_W + 1);
  localparam int YW = cw(DST_H + 1);
  localparam int RW = cw(SCALE);

  localparam logic [AW-1:0] COL_MAX = AW'(SRC_W - 1);
  localparam logic [XW-1:0] X_MAX   = XW'(DST_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(DST_H - 1);
  localparam logic [XW-1:0] X_LO    = XW'(h_off(DST_W, SRC_W, SCALE));
  localparam logic [YW-1:0] Y_LO    = YW'(v_off(DST_H, SRC_H, SCALE));
  localparam logic [XW-1:0] X_SPAN  = XW'(SRC_W * SCALE);
  localparam logic [YW-1:0] Y_SPAN  = YW'(SRC_H * SCALE);
  localparam logic [RW-1:0] REP_MAX = RW'(SCALE - 1);

  // write side
  wr_state_t r_wr_state, w_wr_state_nxt;
  logic            r_fill_idx, w_fill_nxt;
  logic [1:0]      r_full, w_full_nxt, w_full_set, w_full_clr;
  logic [AW-1:0]   r_wcol, w_wcol_nxt, w_waddr;
  logic            r_ready, r_frame_req, r_sync_err;
  logic            w_accept, w_we, w_sync_err_set;

  // read side
  logic [XW-1:0]   r_x, w_x_rel;
  logic [YW-1:0]   r_y, w_y_rel;
  logic [AW-1:0]   r_col;
  logic [RW-1:0]   r_hrep, r_vrep;
  logic            r_rd_idx, w_rd_idx_nxt;
  logic            r_line_bad, r_underrun;
  logic            r_use_ram, r_ram_sel;
  logic [PIXEL_BITS-1:0] r_border_pix;
  logic            w_in_v, w_in_win, w_first, w_bad, w_re, w_release, w_underrun_set;
  logic [PIXEL_BITS-1:0] w_rdata0, w_rdata1;

  always_comb begin
    w_accept       = i_src_valid && r_ready;
    w_we           = 1'b0;
    w_waddr        = r_wcol;
    w_wr_state_nxt = r_wr_state;
    w_wcol_nxt     = r_wcol;
    w_fill_nxt     = r_fill_idx;
    w_full_set     = '0;
    w_sync_err_set = 1'b0;
    if (!i_newframe && w_accept) begin
      if (i_src_sof) begin
        // a start-of-frame pixel always restarts the line at column 0
        w_we           = 1'b1;
        w_waddr        = '0;
        w_wr_state_nxt = WR_RUN;
        w_sync_err_set = (r_wcol != '0);
      end else if (r_wr_state == WR_RUN) begin
        w_we = 1'b1;
      end
      if (w_we) begin
        if (w_waddr == COL_MAX) begin
          w_wcol_nxt             = '0;
          w_full_set[r_fill_idx] = 1'b1;
          w_fill_nxt             = ~r_fill_idx;
        end else begin
          w_wcol_nxt = w_waddr + AW'(1);
        end
      end
    end
    if (i_newframe) begin
      w_wr_state_nxt = WR_WAIT_SOF;
      w_wcol_nxt     = '0;
      w_fill_nxt     = 1'b0;
    end
  end

  always_comb begin
    w_y_rel   = r_y - Y_LO;
    w_x_rel   = r_x - X_LO;
    w_in_v    = (w_y_rel < Y_SPAN);
    w_in_win  = w_in_v && (w_x_rel < X_SPAN);
    w_first   = w_in_win && (w_x_rel == '0);
    w_bad     = w_first ? !r_full[r_rd_idx] : r_line_bad;
    w_re      = i_rd && w_in_win && !w_bad;
    w_underrun_set = i_rd && !i_newline && !i_newframe && w_first && !r_full[r_rd_idx];
    w_release = i_newline && !i_newframe && w_in_v && (r_vrep == REP_MAX);
    w_full_clr = '0;
    if (w_release) w_full_clr[r_rd_idx] = 1'b1;
    // release and fill completion touch separate bits so both land together
    w_full_nxt   = i_newframe ? '0 : ((r_full & ~w_full_clr) | w_full_set);
    w_rd_idx_nxt = i_newframe ? 1'b0 : (w_release ? ~r_rd_idx : r_rd_idx);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_state  <= WR_RUN;
      r_fill_idx  <= 1'b0;
      r_full      <= '0;
      r_wcol      <= '0;
      r_ready     <= 1'b0;
      r_frame_req <= 1'b0;
      r_sync_err  <= 1'b0;
      r_rd_idx    <= 1'b0;
    end else begin
      r_wr_state  <= w_wr_state_nxt;
      r_fill_idx  <= w_fill_nxt;
      r_full      <= w_full_nxt;
      r_wcol      <= w_wcol_nxt;
      r_ready     <= !w_full_nxt[w_fill_nxt];
      r_frame_req <= i_newframe;
      r_rd_idx    <= w_rd_idx_nxt;
      if (w_sync_err_set) r_sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_col        <= '0;
      r_hrep       <= '0;
      r_vrep       <= '0;
      r_line_bad   <= 1'b0;
      r_underrun   <= 1'b0;
      r_use_ram    <= 1'b0;
      r_ram_sel    <= 1'b0;
      r_border_pix <= '0;
    end else begin
      if (w_underrun_set) r_underrun <= 1'b1;
      if (i_rd) begin
        r_use_ram    <= w_re;
        r_ram_sel    <= r_rd_idx;
        r_border_pix <= i_border;
      end
      if (i_newframe) begin
        r_x        <= '0;
        r_y        <= '0;
        r_col      <= '0;
        r_hrep     <= '0;
        r_vrep     <= '0;
        r_line_bad <= 1'b0;
      end else if (i_newline) begin
        r_x        <= '0;
        r_col      <= '0;
        r_hrep     <= '0;
        r_line_bad <= 1'b0;
        if (r_y != Y_MAX) r_y <= r_y + YW'(1);
        if (w_in_v) r_vrep <= (r_vrep == REP_MAX) ? '0 : r_vrep + RW'(1);
      end else if (i_rd) begin
        if (r_x != X_MAX) r_x <= r_x + XW'(1);
        if (w_first) r_line_bad <= !r_full[r_rd_idx];
        // replication counter stands in for (x - H_OFF) / SCALE
        if (w_in_win) begin
          if (r_hrep == REP_MAX) begin
            r_hrep <= '0;
            r_col  <= r_col + AW'(1);
          end else begin
            r_hrep <= r_hrep + RW'(1);
          end
        end
      end
    end
  end

  line_buffer #(.DEPTH(SRC_W), .WIDTH(PIXEL_BITS)) u_lb0 (
    .clk     (clk),
    .i_we    (w_we && !r_fill_idx),
    .i_waddr (w_waddr),
    .i_wdata (i_src_pixel),
    .i_re    (w_re),
    .i_raddr (r_col),
    .o_rdata (w_rdata0)
  );

  line_buffer #(.DEPTH(SRC_W), .WIDTH(PIXEL_BITS)) u_lb1 (
    .clk     (clk),
    .i_we    (w_we && r_fill_idx),
    .i_waddr (w_waddr),
    .i_wdata (i_src_pixel),
    .i_re    (w_re),
    .i_raddr (r_col),
    .o_rdata (w_rdata1)
  );

  assign o_pixel     = r_use_ram ? (r_ram_sel ? w_rdata1 : w_rdata0) : r_border_pix;
  assign o_src_ready = r_ready;
  assign o_frame_req = r_frame_req;
  assign o_underrun  = r_underrun;
  assign o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_frame_scaler.sv
// Directed bench for frame_scaler at default geometry: fill, replay, underrun,
// resync and asynchronous reset.
module tb_frame_scaler;
  import scaler_pkg::*;

  localparam int PB = 24;
  localparam logic [PB-1:0] BORDER = 24'hF0F0F0;

  typedef struct {
    string         name;
    int            tag;
    int            x;
    logic [PB-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_rd = 1'b0, i_newline = 1'b0, i_newframe = 1'b0;
  logic [PB-1:0] o_pixel;
  logic o_underrun, o_sync_err;
  int checks = 0;
  int errors = 0;
  logic [PB-1:0] cap [640];
  vec_t vecs[$];

  frame_scaler_if #(.PIXEL_BITS(PB)) src_if ();

  always #5 clk = ~clk;

  frame_scaler #(
    .SRC_W(256), .SRC_H(240), .DST_W(640), .DST_H(480), .SCALE(2), .PIXEL_BITS(PB)
  ) dut (
    .clk         (clk),
    .i_reset_n   (rst_n),
    .i_src_valid (src_if.valid),
    .i_src_sof   (src_if.sof),
    .i_src_pixel (src_if.pixel),
    .o_src_ready (src_if.ready),
    .o_frame_req (src_if.frame_req),
    .i_rd        (i_rd),
    .i_newline   (i_newline),
    .i_newframe  (i_newframe),
    .i_border    (BORDER),
    .o_pixel     (o_pixel),
    .o_underrun  (o_underrun),
    .o_sync_err  (o_sync_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PB-1:0] pix(input int l, input int n);
    return PB'((l << 8) | n);
  endfunction

  task automatic add_vec(input string name, input int tag, input int x, input logic [PB-1:0] exp);
    vec_t v;
    v.name = name;
    v.tag  = tag;
    v.x    = x;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic push(input logic [PB-1:0] p, input bit sof);
    int unsigned w = 0;
    src_if.valid = 1'b1;
    src_if.sof   = sof;
    src_if.pixel = p;
    while (!src_if.ready && w < 2000) begin
      tick();
      w++;
    end
    if (!src_if.ready) check("push_wait_ready", 32'(src_if.ready), 32'd1);
    tick();
    src_if.valid = 1'b0;
    src_if.sof   = 1'b0;
  endtask

  task automatic push_line(input int l, input int n0, input int n1, input bit sof0);
    for (int n = n0; n <= n1; n++) push(pix(l, n), sof0 && (n == n0));
  endtask

  task automatic read_line();
    i_rd = 1'b1;
    for (int x = 0; x < 640; x++) begin
      tick();
      cap[x] = o_pixel;
    end
    i_rd = 1'b0;
  endtask

  task automatic newline();
    i_newline = 1'b1;
    tick();
    i_newline = 1'b0;
  endtask

  task automatic check_line(input int tag);
    foreach (vecs[i]) if (vecs[i].tag == tag) check(vecs[i].name, 32'(cap[vecs[i].x]), 32'(vecs[i].exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    add_vec("l0_x0", 0, 0, BORDER);     add_vec("l0_x63", 0, 63, BORDER);
    add_vec("l0_x64", 0, 64, 24'h0);    add_vec("l0_x65", 0, 65, 24'h0);
    add_vec("l0_x66", 0, 66, 24'h1);    add_vec("l0_x67", 0, 67, 24'h1);
    add_vec("l0_x320", 0, 320, 24'h80); add_vec("l0_x574", 0, 574, 24'hFF);
    add_vec("l0_x575", 0, 575, 24'hFF); add_vec("l0_x576", 0, 576, BORDER);
    add_vec("l0_x639", 0, 639, BORDER);
    add_vec("l1_x64", 1, 64, 24'h0);    add_vec("l1_x100", 1, 100, 24'h12);
    add_vec("l2_x63", 2, 63, BORDER);   add_vec("l2_x64", 2, 64, 24'h100);
    add_vec("l2_x65", 2, 65, 24'h100);  add_vec("l2_x575", 2, 575, 24'h1FF);
    add_vec("l2_x576", 2, 576, BORDER);
    add_vec("l3_x64", 3, 64, 24'h100);  add_vec("l3_x401", 3, 401, 24'h1A8);
    add_vec("ur_x64", 4, 64, BORDER);   add_vec("ur_x300", 4, 300, BORDER);
    add_vec("ur_x575", 4, 575, BORDER);
    add_vec("rs_x64", 10, 64, 24'h300); add_vec("rs_x65", 10, 65, 24'h300);
    add_vec("rs_x66", 10, 66, 24'h301); add_vec("rs_x263", 10, 263, 24'h363);
    add_vec("rs_x264", 10, 264, 24'h364); add_vec("rs_x575", 10, 575, 24'h3FF);
    add_vec("rs_x639", 10, 639, BORDER);

    src_if.valid = 1'b0;
    src_if.sof   = 1'b0;
    src_if.pixel = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", 32'(o_pixel), 32'h0);
    check("rst_ready", 32'(src_if.ready), 32'd0);
    check("rst_frame_req", 32'(src_if.frame_req), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    check("rst_sync_err", 32'(o_sync_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rel_ready", 32'(src_if.ready), 32'd1);

    push_line(0, 0, 255, 1'b1);
    check("fill0_ready", 32'(src_if.ready), 32'd1);
    push_line(1, 0, 255, 1'b1);
    check("fill1_ready_low", 32'(src_if.ready), 32'd0);

    read_line();
    check_line(0);
    bad = 0;
    for (int x = 0; x < 640; x++)
      if (cap[x] !== ((x < 64 || x >= 576) ? BORDER : PB'((x - 64) / 2))) bad++;
    check("l0_whole_line_mismatches", 32'(bad), 32'd0);

    newline();
    check("nl1_ready_low", 32'(src_if.ready), 32'd0);
    read_line();
    check_line(1);
    newline();
    check("release_ready", 32'(src_if.ready), 32'd1);
    read_line();
    check_line(2);
    newline();
    read_line();
    check_line(3);
    newline();
    check("pre_underrun", 32'(o_underrun), 32'd0);
    read_line();
    check_line(4);
    check("underrun_set", 32'(o_underrun), 32'd1);

    i_newframe = 1'b1;
    tick();
    i_newframe = 1'b0;
    check("frame_req_pulse", 32'(src_if.frame_req), 32'd1);
    tick();
    check("frame_req_end", 32'(src_if.frame_req), 32'd0);
    for (int n = 0; n < 10; n++) push(24'hDEAD00 | PB'(n), 1'b0);
    check("drop_ready", 32'(src_if.ready), 32'd1);
    push_line(2, 0, 99, 1'b1);
    check("partial_no_sync_err", 32'(o_sync_err), 32'd0);
    push_line(3, 0, 0, 1'b1);
    check("sync_err_set", 32'(o_sync_err), 32'd1);
    push_line(3, 1, 255, 1'b0);
    read_line();
    check_line(10);
    check("underrun_sticky", 32'(o_underrun), 32'd1);

    newline();
    i_rd = 1'b1;
    repeat (70) tick();
    check("pre_rst_pixel", 32'(o_pixel), 32'h302);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pixel", 32'(o_pixel), 32'h0);
    check("async_rst_ready", 32'(src_if.ready), 32'd0);
    check("async_rst_frame_req", 32'(src_if.frame_req), 32'd0);
    check("async_rst_underrun", 32'(o_underrun), 32'd0);
    check("async_rst_sync_err", 32'(o_sync_err), 32'd0);
    i_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rel2_ready", 32'(src_if.ready), 32'd1);
    check("rel2_pixel", 32'(o_pixel), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
